// File: rtl/char_message_sequencer_pkg.sv
// rtl/char_message_sequencer_pkg.sv - shared char/position constants and refresh FSM states
package led_mux_pkg;

   localparam int CHAR_W = 4;
   localparam int NUM_POS = 4;
   localparam logic [CHAR_W-1:0] BLANK_CHAR = 4'h0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_e;

endpackage

// File: rtl/char_message_sequencer_if.sv
// rtl/char_message_sequencer_if.sv - switch inputs and display-stage write bus of the sequencer
interface char_message_sequencer_if;
   import led_mux_pkg::*;

   logic [CHAR_W-1:0] push_data;
   logic              push_raw;
   logic              clear_raw;
   logic              scroll_en;
   logic [CHAR_W-1:0] data;
   logic [1:0]        char_position;
   logic              load;
   logic              busy;
   logic              msg_full;
   logic              msg_empty;

   modport master (
      input  push_data, push_raw, clear_raw, scroll_en,
      output data, char_position, load, busy, msg_full, msg_empty
   );

   modport slave (
      output push_data, push_raw, clear_raw, scroll_en,
      input  data, char_position, load, busy, msg_full, msg_empty
   );

endinterface

// File: rtl/input_edge_sync.sv
// rtl/input_edge_sync.sv - 2-FF synchronizer with a one-cycle rising-edge pulse
module input_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/char_message_sequencer.sv
// rtl/char_message_sequencer.sv - message buffer that writes a scrolling 4-char window to the display stage
module char_message_sequencer
   import led_mux_pkg::*;
#(
   parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
   parameter int          MSG_DEPTH  = 16
) (
   input logic                      clk,
   input logic                      reset,
   char_message_sequencer_if.master seq
);

   localparam int PTR_W = $clog2(MSG_DEPTH);
   localparam int LEN_W = PTR_W + 1;

   logic              push_pulse;
   logic              clear_pulse;

   logic [CHAR_W-1:0] msg_q [MSG_DEPTH];
   logic              msg_we;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  start_q, start_d;
   logic [PTR_W-1:0]  offset_q, offset_d;
   logic [LEN_W-1:0]  length_q, length_d;
   logic [23:0]       tick_q, tick_d;
   logic              pending_q, pending_d;

   state_e            state_q, state_d;
   logic [1:0]        pos_q, pos_d;
   logic [CHAR_W-1:0] data_q, data_d;
   logic [1:0]        char_pos_q, char_pos_d;
   logic              load_q, load_d;
   logic              busy_q, busy_d;

   logic [LEN_W-1:0]  win_sum;
   logic [PTR_W-1:0]  win_idx;
   logic [CHAR_W-1:0] win_char;

   input_edge_sync u_push_sync (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (seq.push_raw),
      .pulse_o (push_pulse)
   );

   input_edge_sync u_clear_sync (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (seq.clear_raw),
      .pulse_o (clear_pulse)
   );

   // wr_ptr is zeroed on clear too, so it always equals start+length.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      start_d   = start_q;
      offset_d  = offset_q;
      length_d  = length_q;
      tick_d    = '0;
      pending_d = pending_q;
      msg_we    = 1'b0;

      if (state_q == IDLE && pending_q)
         pending_d = 1'b0;

      if (seq.scroll_en && length_q > LEN_W'(NUM_POS)) begin
         if (tick_q == TICK_COUNT - 24'd1) begin
            tick_d    = '0;
            pending_d = 1'b1;
            if (LEN_W'(offset_q) + LEN_W'(1) >= length_q)
               offset_d = '0;
            else
               offset_d = offset_q + PTR_W'(1);
         end else begin
            tick_d = tick_q + 24'd1;
         end
      end

      if (clear_pulse) begin
         wr_ptr_d  = '0;
         start_d   = '0;
         offset_d  = '0;
         length_d  = '0;
         pending_d = 1'b1;
      end else if (push_pulse) begin
         msg_we    = 1'b1;
         wr_ptr_d  = wr_ptr_q + PTR_W'(1);
         pending_d = 1'b1;
         if (length_q == LEN_W'(MSG_DEPTH))
            start_d = start_q + PTR_W'(1);
         else
            length_d = length_q + LEN_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d = SETUP;
               pos_d   = 2'd0;
            end
         end
         SETUP:  state_d = STROBE;
         STROBE: begin
            if (pos_q == 2'd3) begin
               state_d = IDLE;
            end else begin
               state_d = SETUP;
               pos_d   = pos_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // offset < length, so one conditional subtract reduces (offset+pos) mod length.
   always_comb begin
      win_sum = LEN_W'(offset_q) + LEN_W'(pos_d);
      if (win_sum >= length_q)
         win_sum = win_sum - length_q;
      win_idx  = start_q + win_sum[PTR_W-1:0];
      win_char = (LEN_W'(pos_d) < length_q) ? msg_q[win_idx] : BLANK_CHAR;
   end

   always_comb begin
      data_d     = data_q;
      char_pos_d = char_pos_q;
      if (state_d == SETUP) begin
         data_d     = win_char;
         char_pos_d = pos_d;
      end
      load_d = (state_d == STROBE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         start_q    <= '0;
         offset_q   <= '0;
         length_q   <= '0;
         tick_q     <= '0;
         pending_q  <= 1'b1;
         state_q    <= IDLE;
         pos_q      <= 2'd0;
         data_q     <= '0;
         char_pos_q <= 2'd0;
         load_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         start_q    <= start_d;
         offset_q   <= offset_d;
         length_q   <= length_d;
         tick_q     <= tick_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
         pos_q      <= pos_d;
         data_q     <= data_d;
         char_pos_q <= char_pos_d;
         load_q     <= load_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (msg_we)
         msg_q[wr_ptr_q] <= seq.push_data;
   end

   assign seq.data          = data_q;
   assign seq.char_position = char_pos_q;
   assign seq.load          = load_q;
   assign seq.busy          = busy_q;
   assign seq.msg_full      = (length_q == LEN_W'(MSG_DEPTH));
   assign seq.msg_empty     = (length_q == '0);

endmodule

// File: tb/tb_char_message_sequencer.sv
// tb/tb_char_message_sequencer.sv - scoreboard bench for char_message_sequencer
module tb_char_message_sequencer;

   logic clk;
   logic reset;

   char_message_sequencer_if bus ();

   char_message_sequencer #(
      .TICK_COUNT (24'd4),
      .MSG_DEPTH  (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .seq   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [5:0] sb_q [$];
   logic [3:0] msg_m [$];
   int         off_m = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.load) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_load", 32'd1, 32'd0);
         end else begin
            logic [5:0] e;
            e = sb_q.pop_front();
            check_eq("load_pos", {30'd0, bus.char_position}, {30'd0, e[5:4]});
            check_eq("load_data", {28'd0, bus.data}, {28'd0, e[3:0]});
         end
      end
   end

   task automatic push_expected();
      for (int p = 0; p < 4; p++) begin
         logic [3:0] c;
         logic [1:0] pp;
         pp = p[1:0];
         if (p < msg_m.size())
            c = msg_m[(off_m + p) % msg_m.size()];
         else
            c = 4'h0;
         sb_q.push_back({pp, c});
      end
   endtask

   task automatic model_push(input logic [3:0] d);
      if (msg_m.size() == 16)
         void'(msg_m.pop_front());
      msg_m.push_back(d);
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while (!bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("refresh_start", {31'd0, bus.busy}, 32'd1);
      n = 0;
      while (bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("refresh_end", {31'd0, bus.busy}, 32'd0);
      check_eq("sb_drained", sb_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      int busy_cnt;
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      msg_m.delete();
      off_m = 0;
      push_expected();
      repeat (3) @(negedge clk);
      check_eq("rst_data", {28'd0, bus.data}, 32'd0);
      check_eq("rst_pos", {30'd0, bus.char_position}, 32'd0);
      check_eq("rst_load", {31'd0, bus.load}, 32'd0);
      check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("rst_full", {31'd0, bus.msg_full}, 32'd0);
      check_eq("rst_empty", {31'd0, bus.msg_empty}, 32'd1);
      reset = 1'b0;
      busy_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
      end
      check_eq("blank_busy_cycles", busy_cnt, 32'd8);
      check_eq("blank_drained", sb_q.size(), 32'd0);
   endtask

   task automatic do_push(input logic [3:0] d);
      bus.push_data = d;
      bus.push_raw  = 1'b1;
      model_push(d);
      push_expected();
      repeat (4) @(negedge clk);
      bus.push_raw = 1'b0;
      wait_quiet();
   endtask

   task automatic do_scroll();
      off_m = (off_m + 1) % msg_m.size();
      push_expected();
      bus.scroll_en = 1'b1;
      repeat (4) @(negedge clk);
      bus.scroll_en = 1'b0;
      wait_quiet();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset         = 1'b1;
      bus.push_data = 4'h0;
      bus.push_raw  = 1'b0;
      bus.clear_raw = 1'b0;
      bus.scroll_en = 1'b0;

      // 1: reset and blank refresh
      do_reset();

      // 2: three pushes without scrolling
      do_push(4'h1);
      do_push(4'h2);
      do_push(4'h3);
      check_eq("t2_empty", {31'd0, bus.msg_empty}, 32'd0);

      // 3: six chars, scroll through all offsets
      do_reset();
      for (int i = 1; i <= 6; i++) do_push(i[3:0]);
      for (int i = 0; i < 6; i++) do_scroll();
      check_eq("t3_offset_wrapped", off_m, 32'd0);

      // 4: fill and overflow
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_push(i[3:0]);
         check_eq("t4_full", {31'd0, bus.msg_full}, (i == 15) ? 32'd1 : 32'd0);
      end
      do_push(4'h1);
      check_eq("t4_full_after_drop", {31'd0, bus.msg_full}, 32'd1);

      // 5: clear and push in the same cycle, clear wins
      bus.push_data = 4'h9;
      bus.push_raw  = 1'b1;
      bus.clear_raw = 1'b1;
      msg_m.delete();
      off_m = 0;
      push_expected();
      repeat (4) @(negedge clk);
      bus.push_raw  = 1'b0;
      bus.clear_raw = 1'b0;
      wait_quiet();
      check_eq("t5_empty", {31'd0, bus.msg_empty}, 32'd1);
      check_eq("t5_full", {31'd0, bus.msg_full}, 32'd0);

      // 6: reset during the STROBE of position 2
      do_reset();
      bus.push_data = 4'h7;
      bus.push_raw  = 1'b1;
      model_push(4'h7);
      push_expected();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.load && bus.char_position == 2'd2) && n < 40);
      check_eq("t6_reached_pos2", {31'd0, bus.load}, 32'd1);
      bus.push_raw = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_load_drop", {31'd0, bus.load}, 32'd0);
      check_eq("t6_busy_drop", {31'd0, bus.busy}, 32'd0);
      sb_q.delete();
      msg_m.delete();
      off_m = 0;
      push_expected();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_quiet();
      check_eq("t6_empty", {31'd0, bus.msg_empty}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
